muldiv_sequencer: RTL and testbench

- Sequences the shared multiply and divide units for the multicycle core on behalf of the control unit.
- Accepts a one-cycle op request and issues the matching start pulse.
- Waits for completion, then loads Hi/Lo with the correct mux selects; divide-by-zero becomes an exception pulse.
- Stalls mfhi/mflo-style reads while an operation is in flight. Sits between control_unit and the mult/div/Hi/Lo datapath.

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/muldiv_watchdog.sv | 24 ++
 rtl/muldiv_sequencer.sv | 100 ++++++++++
 tb/tb_muldiv_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: sequencer states and Hi/Lo source select encodings
package muldiv_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, EXC_DZ, EXC_TO} state_t;

    localparam logic SEL_DIV  = 1'b0;
    localparam logic SEL_MULT = 1'b1;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: counts WAIT cycles and flags the cycle on which the limit is reached
module muldiv_watchdog #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // restart on entry to WAIT, advance once per WAIT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: starts mult/div, loads Hi/Lo on completion, stalls Hi/Lo reads while busy (MULDIV_WATCHDOG_EN adds a WAIT timeout)
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic op_start,
    input  logic op_is_div,
    input  logic mult_stop,
    input  logic div_stop,
    input  logic div_zero,
    input  logic hilo_read,
    output logic mult_control,
    output logic div_control,
    output logic sel_mux_hi,
    output logic sel_mux_lo,
    output logic HiLo_load,
    output logic busy,
    output logic stall,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_exc
);

    state_t state_q, state_d;
    logic   is_div_q, is_div_d, sel_q, wd_expired;

    if (2**CNT_W <= MAX_CYCLES) begin : g_cnt_w_check
        $error("muldiv_sequencer: CNT_W too narrow for MAX_CYCLES");
    end

`ifdef MULDIV_WATCHDOG_EN
    muldiv_watchdog #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q == START),
        .en      (state_q == WAIT),
        .expired (wd_expired)
    );

    // timeout pulse accompanies the single EXC_TO cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timeout_exc <= 1'b0;
        else timeout_exc <= state_d == EXC_TO;
    end
`else
    assign wd_expired  = 1'b0;
    assign timeout_exc = 1'b0;
`endif

    // next state; only the active unit's stop/zero counts, and only in WAIT
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        case (state_q)
            IDLE: begin
                state_d  = op_start ? START : IDLE;
                is_div_d = op_start ? op_is_div : is_div_q;
            end
            START:   state_d = WAIT;
            WAIT:    state_d = (is_div_q && div_zero) ? EXC_DZ :
                               (is_div_q ? div_stop : mult_stop) ? WRITE :
                               wd_expired ? EXC_TO : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // state register and outputs registered from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            is_div_q     <= 1'b0;
            sel_q        <= 1'b0;
            mult_control <= 1'b0;
            div_control  <= 1'b0;
            HiLo_load    <= 1'b0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_div_q     <= is_div_d;
            sel_q        <= (state_d == START) ? (is_div_d ? SEL_DIV : SEL_MULT) : sel_q;
            mult_control <= (state_d == START) && !is_div_d;
            div_control  <= (state_d == START) && is_div_d;
            HiLo_load    <= state_d == WRITE;
            done         <= state_d == WRITE;
            div_zero_exc <= state_d == EXC_DZ;
            busy         <= state_d != IDLE;
        end
    end

    assign sel_mux_hi = sel_q;
    assign sel_mux_lo = sel_q;
    assign stall      = hilo_read & busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random stimulus against a timestamp-based reference model
module tb_muldiv_sequencer;

    localparam int MAX = 40;

    logic clk = 1'b0, reset = 1'b0;
    logic op_start = 1'b0, op_is_div = 1'b0, mult_stop = 1'b0, div_stop = 1'b0;
    logic div_zero = 1'b0, hilo_read = 1'b0;
    logic mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load;
    logic busy, stall, done, div_zero_exc, timeout_exc;

    int n_cmp = 0, n_bad = 0, e = 0;
    bit in_op = 0, kdiv = 0, m_sel = 0;
    int acc = 0, fin = -1, res = 0;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_is_div(op_is_div),
        .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero), .hilo_read(hilo_read),
        .mult_control(mult_control), .div_control(div_control), .sel_mux_hi(sel_mux_hi),
        .sel_mux_lo(sel_mux_lo), .HiLo_load(HiLo_load), .busy(busy), .stall(stall),
        .done(done), .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (mc dc hi lo load busy stall done dz to)", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load,
                busy, stall, done, div_zero_exc, timeout_exc};
    endfunction

    // expected outputs after edge e: start pulse on the accept edge, result one edge after the stop
    function automatic logic [9:0] expected();
        bit fired = in_op && fin == e;
        return {in_op && e == acc && !kdiv, in_op && e == acc && kdiv, m_sel, m_sel,
                fired && res == 1, in_op, hilo_read && in_op, fired && res == 1,
                fired && res == 2, fired && res == 3};
    endfunction

    // one operation's life: accepted at edge acc, stop seen from acc+2, finished at fin, idle after fin+1
    task automatic model_edge();
        if (in_op) begin
            if (fin < 0 && e >= acc + 2) begin
                if (kdiv && div_zero) begin fin = e; res = 2; end
                else if (kdiv ? div_stop : mult_stop) begin fin = e; res = 1; end
`ifdef MULDIV_WATCHDOG_EN
                else if (e == acc + 1 + MAX) begin fin = e; res = 3; end
`endif
            end else if (fin >= 0 && e == fin + 1) in_op = 0;
        end else if (op_start) begin
            in_op = 1; acc = e; fin = -1; kdiv = op_is_div; m_sel = !op_is_div;
        end
    endtask

    task automatic cyc(input bit op, input bit dv, input bit ms, input bit ds, input bit dz, input bit rd);
        @(negedge clk);
        reset = 1'b1; op_start = op; op_is_div = dv;
        mult_stop = ms; div_stop = ds; div_zero = dz; hilo_read = rd;
        @(posedge clk);
        e++;
        model_edge();
        #1 check($sformatf("cyc%0d", e), outs(), expected());
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rd);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0; in_op = 0; m_sel = 0;
        #1 check("rst_async", outs(), 10'b0);
        @(posedge clk);
        e++;
        #1 check("rst_hold", outs(), 10'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset", outs(), 10'b0);
        // mult with a cross-unit div_stop that must be ignored
        idle(1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(10, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(20, 0);
        cyc(0, 0, 1, 0, 0, 0);
        idle(3, 0);
        // divide by zero
        cyc(1, 1, 0, 0, 0, 0);
        idle(2, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(3, 0);
        // stall, stop during START, mult_stop and second op_start while busy
        cyc(1, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        idle(3, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        idle(5, 1);
        cyc(0, 0, 0, 1, 0, 1);
        idle(3, 1);
        // reset while waiting, then a normal mult
        cyc(1, 1, 0, 0, 0, 0);
        idle(4, 1);
        pulse_reset();
        cyc(1, 0, 0, 0, 0, 0);
        idle(5, 0);
        cyc(0, 0, 1, 0, 0, 1);
        idle(2, 1);
        // long wait: watchdog expiry when enabled, otherwise still busy
        cyc(1, 1, 0, 0, 0, 0);
        idle(50, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2, 0);
        // back-to-back: div accepted in the idle cycle right after WRITE
        cyc(1, 0, 0, 0, 0, 0);
        idle(3, 0);
        cyc(0, 0, 1, 0, 0, 0);
        idle(1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        idle(3, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) pulse_reset();
            else cyc($urandom_range(3) == 0, 1'($urandom_range(1)), $urandom_range(7) == 0,
                     $urandom_range(7) == 0, $urandom_range(15) == 0, 1'($urandom_range(1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
